sr_pulse_driver: RTL and testbench

SR_PULSE_DRIVER -- requirements
Module: sr_pulse_driver

---
 rtl/sr_pulse_driver.sv | 170 +++++++++++++++++
 tb/tb_sr_pulse_driver.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_pulse_driver.sv
// Queues set/reset commands and turns each one into a timed pulse on a downstream
// SR flip-flop, then samples the flop's q to confirm it reached the expected state.
module sr_pulse_driver #(
  parameter int DEPTH   = 4,
  parameter int GAP_CYC = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_op,
  input  logic [3:0] req_width,
  output logic       set_o,
  output logic       rst_o,
  input  logic       q_in,
  output logic       exp_q,
  output logic       busy,
  output logic       err,
  input  logic       err_clr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam int CNT_W = (GAP_W > 4) ? GAP_W : 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [4:0]       mem_q [DEPTH];
  logic [4:0]       mem_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             set_q, set_d;
  logic             rst_q, rst_d;
  logic             exp_q_q, exp_q_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic             push;
  logic             pop;
  logic             head_op;
  logic [3:0]       head_width;

  // No bypass: readiness depends only on the registered occupancy.
  assign req_ready = (occ_q < OCC_W'(DEPTH));
  assign set_o     = set_q;
  assign rst_o     = rst_q;
  assign exp_q     = exp_q_q;
  assign err       = err_q;
  assign busy      = busy_q;

  always_comb begin
    push       = req_valid && req_ready && reset;
    pop        = (state_q == IDLE) && (occ_q != '0);
    head_op    = mem_q[rd_ptr_q][4];
    head_width = mem_q[rd_ptr_q][3:0];

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {req_op, req_width};
    end

    wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // set_d and rst_d are only ever loaded as a complementary pair or both cleared,
  // so the two outputs can never be high together.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    set_d   = set_q;
    rst_d   = rst_q;
    exp_q_d = exp_q_q;
    err_d   = err_q;

    if (err_clr) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = PULSE;
          cnt_d   = (head_width == 4'd0) ? CNT_W'(1) : CNT_W'(head_width);
          set_d   = head_op;
          rst_d   = !head_op;
          exp_q_d = head_op;
        end
      end
      PULSE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = GAP;
          cnt_d   = CNT_W'(GAP_CYC);
          set_d   = 1'b0;
          rst_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CHECK: begin
        if (q_in != exp_q_q) begin
          err_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        set_d   = 1'b0;
        rst_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE) || (occ_d != '0);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
      set_q    <= 1'b0;
      rst_q    <= 1'b0;
      exp_q_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      set_q    <= set_d;
      rst_q    <= rst_d;
      exp_q_q  <= exp_q_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are valid.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Directed and random checks for sr_pulse_driver; a scoreboard matches every
// accepted command against the pulse observed on set_o/rst_o.
module tb_sr_pulse_driver;

  localparam int DEPTH   = 4;
  localparam int GAP_CYC = 2;

  logic       clock     = 1'b0;
  logic       reset     = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_op    = 1'b0;
  logic [3:0] req_width = 4'd0;
  logic       err_clr   = 1'b0;
  logic       q_in;
  logic       req_ready;
  logic       set_o;
  logic       rst_o;
  logic       exp_q;
  logic       busy;
  logic       err;

  logic       q_follow = 1'b1;
  logic       q_force  = 1'b0;
  logic       ff_q     = 1'b0;

  int         total = 0;
  int         bad   = 0;
  logic [4:0] sb[$];

  logic       mon_active = 1'b0;
  logic       mon_op     = 1'b0;
  logic       mon_prev   = 1'b0;
  int         mon_len    = 0;
  int         mon_gap    = 0;
  logic [4:0] mon_exp;
  logic [3:0] mon_len4;

  logic       b2b_op [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [3:0] b2b_w  [5] = '{4'd2, 4'd5, 4'd0, 4'd1, 4'd3};

  sr_pulse_driver #(
    .DEPTH  (DEPTH),
    .GAP_CYC(GAP_CYC)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_width(req_width),
    .set_o    (set_o),
    .rst_o    (rst_o),
    .q_in     (q_in),
    .exp_q    (exp_q),
    .busy     (busy),
    .err      (err),
    .err_clr  (err_clr)
  );

  always #5 clock = ~clock;

  // Ideal downstream SR flop, unless the bench forces q_in.
  assign q_in = q_follow ? ff_q : q_force;

  always @(posedge clock) begin
    if (set_o) ff_q <= 1'b1;
    else if (rst_o) ff_q <= 1'b0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic op, input logic [3:0] w);
    req_valid = v;
    req_op    = op;
    req_width = w;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic pushCmd(input logic op, input logic [3:0] w);
    applyStimulus(1'b1, op, w);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 4'd0);
  endtask

  task automatic waitIdle(input int bound);
    int n;
    n = 0;
    @(negedge clock);
    while (busy && n < bound) begin
      @(negedge clock);
      n++;
    end
    checkOutput("drain_busy", busy, 0);
  endtask

  task automatic doReset(input int cycles);
    reset = 1'b0;
    sb.delete();
    repeat (cycles) nextCycle();
    reset = 1'b1;
  endtask

  // Pulse monitor: records accepted commands, measures each pulse, checks order,
  // width, spacing and mutual exclusion of the two drive outputs.
  always @(negedge clock) begin
    if (!reset) begin
      mon_active = 1'b0;
      mon_prev   = 1'b0;
      mon_gap    = 0;
    end else begin
      if (req_valid && req_ready)
        sb.push_back({req_op, (req_width == 4'd0) ? 4'd1 : req_width});
      checkOutput("no_overlap", {31'd0, set_o & rst_o}, 0);
      if (mon_active) begin
        if (mon_op ? set_o : rst_o) begin
          mon_len++;
        end else begin
          mon_active = 1'b0;
          mon_prev   = 1'b1;
          mon_gap    = 0;
          if (sb.size() == 0) begin
            checkOutput("sb_underflow", 1, 0);
          end else begin
            mon_exp  = sb.pop_front();
            mon_len4 = 4'(mon_len);
            checkOutput("pulse_op_width", {27'd0, mon_op, mon_len4}, {27'd0, mon_exp});
          end
        end
      end
      if (!mon_active) begin
        if (set_o || rst_o) begin
          if (mon_prev) checkOutput("pulse_gap", {31'd0, mon_gap >= GAP_CYC + 2}, 1);
          mon_active = 1'b1;
          mon_op     = set_o;
          mon_len    = 1;
        end else begin
          mon_gap++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int accepted;
    int stall;
    logic full_checked;
    logic seen;

    // Reset state
    doReset(3);
    @(negedge clock);
    checkOutput("rst_set_o", set_o, 0);
    checkOutput("rst_rst_o", rst_o, 0);
    checkOutput("rst_exp_q", exp_q, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", req_ready, 1);

    // Single set pulse of width 3: high after pop edge N+1 for three cycles
    pushCmd(1'b1, 4'd3);
    for (int j = 0; j < 8; j++) begin
      @(negedge clock);
      checkOutput("w3_set", set_o, {31'd0, (j >= 1 && j <= 3)});
      checkOutput("w3_rst", rst_o, 0);
      checkOutput("w3_busy", busy, {31'd0, (j < 7)});
    end
    checkOutput("w3_exp_q", exp_q, 1);
    checkOutput("w3_err", err, 0);

    // Width 0 behaves as width 1
    pushCmd(1'b0, 4'd0);
    for (int j = 0; j < 5; j++) begin
      @(negedge clock);
      checkOutput("w0_rst", rst_o, {31'd0, (j == 1)});
      checkOutput("w0_set", set_o, 0);
    end
    waitIdle(50);
    checkOutput("w0_exp_q", exp_q, 0);
    checkOutput("w0_err", err, 0);

    // Fill the FIFO behind a long pulse; the fifth push must stall until a pop
    pushCmd(1'b1, 4'd15);
    repeat (2) nextCycle();
    accepted     = 0;
    stall        = 0;
    full_checked = 1'b0;
    for (int n = 0; n < 100 && accepted < 5; n++) begin
      applyStimulus(1'b1, b2b_op[accepted], b2b_w[accepted]);
      @(negedge clock);
      if (accepted == 4 && !full_checked) begin
        checkOutput("full_ready", req_ready, 0);
        checkOutput("full_busy", busy, 1);
        full_checked = 1'b1;
      end
      if (req_ready) accepted++;
      else stall++;
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 4'd0);
    checkOutput("b2b_accepted", accepted, 5);
    checkOutput("b2b_stalled", {31'd0, stall > 0}, 1);
    waitIdle(300);
    checkOutput("b2b_sb_empty", sb.size(), 0);
    checkOutput("b2b_err", err, 0);

    // Mismatch makes err sticky; err_clr clears it on the next edge
    q_follow = 1'b0;
    q_force  = 1'b0;
    pushCmd(1'b1, 4'd2);
    waitIdle(50);
    checkOutput("err_set", err, 1);
    repeat (3) @(negedge clock);
    checkOutput("err_sticky", err, 1);
    nextCycle();
    err_clr = 1'b1;
    nextCycle();
    err_clr = 1'b0;
    @(negedge clock);
    checkOutput("err_clear", err, 0);

    // A mismatch on the same edge as err_clr wins
    applyStimulus(1'b1, 1'b1, 4'd1);
    err_clr = 1'b1;
    nextCycle();
    applyStimulus(1'b0, 1'b0, 4'd0);
    repeat (5) nextCycle();
    err_clr = 1'b0;
    @(negedge clock);
    checkOutput("err_clr_vs_check", err, 1);
    nextCycle();
    err_clr = 1'b1;
    nextCycle();
    err_clr  = 1'b0;
    q_follow = 1'b1;
    @(negedge clock);
    checkOutput("err_clear2", err, 0);

    // Reset during the second cycle of a width-4 set pulse, with one entry pending
    pushCmd(1'b1, 4'd4);
    applyStimulus(1'b1, 1'b0, 4'd3);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 4'd0);
    @(negedge clock);
    checkOutput("mid_pre_set", set_o, 1);
    nextCycle();
    doReset(1);
    @(negedge clock);
    checkOutput("mid_set", set_o, 0);
    checkOutput("mid_rst", rst_o, 0);
    checkOutput("mid_busy", busy, 0);
    checkOutput("mid_exp_q", exp_q, 0);
    checkOutput("mid_ready", req_ready, 1);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (set_o || rst_o || busy) seen = 1'b1;
    end
    checkOutput("mid_pending_lost", seen, 0);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      applyStimulus($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)));
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 4'd0);
    waitIdle(500);
    checkOutput("rand_sb_empty", sb.size(), 0);
    checkOutput("rand_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
